// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// f_d_reg_t is the F/D pipeline register layout consumed by decode.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_4;
    } f_d_reg_t;

    // Modular 32-bit increment; 32'hFFFF_FFFC wraps to zero.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched F/D record while decode is stalled.
// Clear has priority over load, load over drain.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_load,
    input  f_d_reg_t i_load_data,
    input  logic     i_drain,
    input  logic     i_clear,
    output logic     o_valid,
    output f_d_reg_t o_data
);

    logic     r_valid;
    f_d_reg_t r_data;

    // Entry storage with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the single-outstanding
// instruction-bus handshake, absorbs stalls and applies branch/jump redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        fd_valid,
    output f_d_reg_t    fd,
    output logic [31:0] pc_f
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    f_d_reg_t     r_fd;
    logic         r_fd_valid;
    logic         r_discard;
    logic         r_redir_pend;
    logic [31:0]  r_redir_pc;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    f_d_reg_t     w_fd_nxt;
    logic         w_fd_valid_nxt;
    logic         w_discard_nxt;
    logic         w_redir_pend_nxt;
    logic [31:0]  w_redir_pc_nxt;

    logic         w_buf_load;
    logic         w_buf_drain;
    logic         w_buf_clear;
    logic         w_buf_valid;
    f_d_reg_t     w_buf_data;

    logic [31:0]  w_pc_plus_4;
    f_d_reg_t     w_fetched;
    logic         w_complete;

    assign w_pc_plus_4 = pc_inc(r_pc);
    assign w_fetched   = '{instruction: iresp_data, pc_plus_4: w_pc_plus_4};
    // A transaction finishes on data_ok once the address has been accepted.
    assign w_complete  = ((r_state == REQ) && iresp_addr_ok && iresp_data_ok) ||
                         ((r_state == WAIT) && iresp_data_ok);

    fetch_skid_buf u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_buf_load),
        .i_load_data (w_fetched),
        .i_drain     (w_buf_drain),
        .i_clear     (w_buf_clear),
        .o_valid     (w_buf_valid),
        .o_data      (w_buf_data)
    );

    // Next-state, PC, F/D register and skid-buffer control.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fd_nxt         = r_fd;
        w_fd_valid_nxt   = r_fd_valid;
        w_discard_nxt    = r_discard;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        w_buf_load       = 1'b0;
        w_buf_drain      = 1'b0;
        w_buf_clear      = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_fd_valid_nxt = 1'b0;
                    w_buf_clear    = 1'b1;
                end else if (!stall) begin
                    w_fd_valid_nxt = 1'b0;
                end else begin
                    w_fd_valid_nxt = r_fd_valid;
                end
            end

            REQ, WAIT: begin
                if (w_complete) begin
                    w_state_nxt = REQ;
                    if (redirect_valid) begin
                        w_pc_nxt         = redirect_pc;
                        w_discard_nxt    = 1'b0;
                        w_redir_pend_nxt = 1'b0;
                        w_fd_valid_nxt   = 1'b0;
                    end else if (r_discard) begin
                        // Response belongs to the wrong path: drop it and refetch.
                        w_pc_nxt         = r_redir_pc;
                        w_discard_nxt    = 1'b0;
                        w_redir_pend_nxt = 1'b0;
                        w_fd_valid_nxt   = stall ? r_fd_valid : 1'b0;
                    end else if (!stall) begin
                        w_fd_nxt       = w_fetched;
                        w_fd_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc_plus_4;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    if (redirect_valid) begin
                        w_redir_pend_nxt = 1'b1;
                        w_redir_pc_nxt   = redirect_pc;
                        w_discard_nxt    = 1'b1;
                        w_fd_valid_nxt   = 1'b0;
                    end else if (!stall) begin
                        w_fd_valid_nxt = 1'b0;
                    end else begin
                        w_fd_valid_nxt = r_fd_valid;
                    end
                    if ((r_state == REQ) && iresp_addr_ok) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_buf_clear    = 1'b1;
                    w_fd_valid_nxt = 1'b0;
                    w_state_nxt    = REQ;
                end else if (!stall && w_buf_valid) begin
                    w_fd_nxt       = w_buf_data;
                    w_fd_valid_nxt = 1'b1;
                    w_buf_drain    = 1'b1;
                    w_pc_nxt       = w_pc_plus_4;
                    w_state_nxt    = REQ;
                end else if (!stall) begin
                    w_fd_valid_nxt = 1'b0;
                    w_state_nxt    = REQ;
                end else begin
                    w_state_nxt = HOLD;
                end
            end

            default: begin
                w_state_nxt    = IDLE;
                w_fd_valid_nxt = 1'b0;
            end
        endcase
    end

    // Fetch state registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_fd         <= '0;
            r_fd_valid   <= 1'b0;
            r_discard    <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0000_0000;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fd         <= w_fd_nxt;
            r_fd_valid   <= w_fd_valid_nxt;
            r_discard    <= w_discard_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
        end
    end

    assign ireq_valid = (r_state == REQ);
    assign ireq_addr  = r_pc;
    assign pc_f       = r_pc;
    assign fd_valid   = r_fd_valid;
    assign fd         = r_fd;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with hand-written reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = 32'h0;
    logic        fd_valid;
    logic [63:0] fd;
    logic [31:0] pc_f;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        aok;
        logic        dok;
        logic [31:0] data;
        logic        e_iv;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [63:0] e_fd;
    } vec_t;

    vec_t vq[$];

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .fd_valid       (fd_valid),
        .fd             (fd),
        .pc_f           (pc_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic aok, input logic dok, input logic [31:0] data,
                       input logic e_iv, input logic [31:0] e_addr,
                       input logic e_fv, input logic [63:0] e_fd);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.aok = aok; v.dok = dok; v.data = data;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_fd = e_fd;
        vq.push_back(v);
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                         input logic aok, input logic dok, input logic [31:0] data);
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        iresp_addr_ok = aok; iresp_data_ok = dok; iresp_data = data;
    endtask

    initial begin
        // Inputs are applied at a negedge; outputs checked at the next negedge.
        //  st rv rpc           aok dok data          iv  addr          fv  fd
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0000, 0, 64'h0);
        add(0, 0, 32'h0,         1, 1, 32'h2008_0005, 1, 32'h8000_0004, 1, 64'h2008_0005_8000_0004);
        add(0, 0, 32'h0,         1, 1, 32'h2009_0003, 1, 32'h8000_0008, 1, 64'h2009_0003_8000_0008);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h8000_0008, 0, 64'h2009_0003_8000_0008);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8000_0008, 0, 64'h2009_0003_8000_0008);
        add(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8000_0008, 0, 64'h2009_0003_8000_0008);
        add(0, 0, 32'h0,         0, 1, 32'h1111_2222, 1, 32'h8000_000C, 1, 64'h1111_2222_8000_000C);
        add(1, 0, 32'h0,         1, 1, 32'h8C08_0000, 0, 32'h8000_000C, 1, 64'h1111_2222_8000_000C);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8000_000C, 1, 64'h1111_2222_8000_000C);
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8000_000C, 1, 64'h1111_2222_8000_000C);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0010, 1, 64'h8C08_0000_8000_0010);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h8000_0010, 0, 64'h8C08_0000_8000_0010);
        add(0, 1, 32'h8000_0100, 0, 0, 32'h0,         0, 32'h8000_0010, 0, 64'h8C08_0000_8000_0010);
        add(0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF, 1, 32'h8000_0100, 0, 64'h8C08_0000_8000_0010);
        add(0, 0, 32'h0,         1, 1, 32'h2010_0001, 1, 32'h8000_0104, 1, 64'h2010_0001_8000_0104);
        add(1, 1, 32'h8000_0200, 1, 1, 32'hBAD0_BAD0, 1, 32'h8000_0200, 0, 64'h2010_0001_8000_0104);
        add(1, 0, 32'h0,         1, 1, 32'h3333_4444, 0, 32'h8000_0200, 0, 64'h2010_0001_8000_0104);
        add(1, 1, 32'h8000_0300, 0, 0, 32'h0,         1, 32'h8000_0300, 0, 64'h2010_0001_8000_0104);
        add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h8000_0300, 0, 64'h2010_0001_8000_0104);
        add(0, 1, 32'h8000_0400, 0, 0, 32'h0,         0, 32'h8000_0300, 0, 64'h2010_0001_8000_0104);
        add(0, 1, 32'h8000_0500, 0, 0, 32'h0,         0, 32'h8000_0300, 0, 64'h2010_0001_8000_0104);
        add(0, 0, 32'h0,         0, 1, 32'h5555_5555, 1, 32'h8000_0500, 0, 64'h2010_0001_8000_0104);
        add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h7777_0000, 1, 32'hFFFF_FFFC, 0, 64'h2010_0001_8000_0104);
        add(0, 0, 32'h0,         1, 1, 32'h6666_7777, 1, 32'h0000_0000, 1, 64'h6666_7777_0000_0000);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 1, 64'h6666_7777_0000_0000);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 64'h6666_7777_0000_0000);

        #2 reset = 1'b1;
        #1;
        chk("rst_iv", {63'h0, ireq_valid}, 64'h0);
        chk("rst_fv", {63'h0, fd_valid}, 64'h0);
        chk("rst_fd", fd, 64'h0);
        chk("rst_pc", {32'h0, pc_f}, 64'h8000_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("idle_iv", {63'h0, ireq_valid}, 64'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].rv, vq[i].rpc, vq[i].aok, vq[i].dok, vq[i].data);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_iv", i), {63'h0, ireq_valid}, {63'h0, vq[i].e_iv});
            chk($sformatf("v%0d_addr", i), {32'h0, ireq_addr}, {32'h0, vq[i].e_addr});
            chk($sformatf("v%0d_pcf", i), {32'h0, pc_f}, {32'h0, vq[i].e_addr});
            chk($sformatf("v%0d_fv", i), {63'h0, fd_valid}, {63'h0, vq[i].e_fv});
            chk($sformatf("v%0d_fd", i), fd, vq[i].e_fd);
        end

        // Asynchronous reset while waiting for data.
        drive(0, 0, 32'h0, 1, 1, 32'h2011_0007);
        @(posedge clk); @(negedge clk);
        chk("pre_fd", fd, 64'h2011_0007_0000_0004);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("wait_iv", {63'h0, ireq_valid}, 64'h0);
        chk("wait_fv", {63'h0, fd_valid}, 64'h1);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("arst_iv", {63'h0, ireq_valid}, 64'h0);
        chk("arst_fv", {63'h0, fd_valid}, 64'h0);
        chk("arst_fd", fd, 64'h0);
        chk("arst_pc", {32'h0, pc_f}, 64'h8000_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 1, 32'hBADB_AD00);
        @(posedge clk); @(negedge clk);
        chk("late_iv", {63'h0, ireq_valid}, 64'h1);
        chk("late_addr", {32'h0, ireq_addr}, 64'h8000_0000);
        chk("late_fv", {63'h0, fd_valid}, 64'h0);
        drive(0, 0, 32'h0, 1, 1, 32'h2012_0008);
        @(posedge clk); @(negedge clk);
        chk("post_fd", fd, 64'h2012_0008_8000_0004);
        chk("post_fv", {63'h0, fd_valid}, 64'h1);

        // Asynchronous reset while a request is on the bus.
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("req_iv", {63'h0, ireq_valid}, 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("rreq_iv", {63'h0, ireq_valid}, 64'h0);
        chk("rreq_fv", {63'h0, fd_valid}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
